// File: rtl/rf_hazard_scoreboard.sv
// rf_hazard_scoreboard: issue-stage scoreboard for the 16x32 register file.
// Counts in-flight writes per register, stalls decode on RAW/WAW-saturation
// hazards and holds the PC (HZPCld=0) while a write to R15 is outstanding.
module rf_hazard_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ID_VALID,
    input  logic [3:0]  ID_SA,
    input  logic [3:0]  ID_SB,
    input  logic [3:0]  ID_SD,
    input  logic [2:0]  ID_USE,
    input  logic        ID_WR,
    input  logic [3:0]  ID_C,
    input  logic        WB_VALID,
    input  logic [3:0]  WB_C,
    input  logic        FLUSH,
    output logic        ISSUE,
    output logic        STALL,
    output logic        HZPCld,
    output logic [15:0] PEND,
    output logic        ERR
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN,
        PC_WAIT
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt     [16];
    logic [CNT_W-1:0] cntNext [16];
    logic [15:0]      incVec;
    logic [15:0]      decVec;
    logic [15:0]      pendNext;
    logic             errNext;
    logic             hazard;

    // Source registers with pending writes, or a destination counter already full, block issue.
    always_comb begin
        hazard = (ID_USE[0] && (cnt[ID_SA] != '0))
               | (ID_USE[1] && (cnt[ID_SB] != '0))
               | (ID_USE[2] && (cnt[ID_SD] != '0))
               | (ID_WR && (cnt[ID_C] == CNT_MAX));
    end

    // Handshake outputs; reset forces the idle values, PC_WAIT holds decode and the PC.
    always_comb begin
        STALL  = 1'b0;
        ISSUE  = 1'b0;
        HZPCld = 1'b1;
        if (RST) begin
            if (state == PC_WAIT) begin
                STALL  = 1'b1;
                HZPCld = 1'b0;
            end else begin
                STALL  = ID_VALID & hazard;
                HZPCld = ~(ID_VALID & hazard);
                ISSUE  = ID_VALID & ~hazard & ~FLUSH;
            end
        end
    end

    // One-hot increment/decrement requests; a retire only counts if a write is outstanding.
    always_comb begin
        incVec = '0;
        decVec = '0;
        if (ISSUE && ID_WR) begin
            incVec[ID_C] = 1'b1;
        end
        if (WB_VALID && (cnt[WB_C] != '0)) begin
            decVec[WB_C] = 1'b1;
        end
    end

    // Next counter values; flush wipes everything, simultaneous inc and dec cancel.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            cntNext[r] = cnt[r];
            if (FLUSH) begin
                cntNext[r] = '0;
            end else if (incVec[r] && !decVec[r]) begin
                cntNext[r] = cnt[r] + CNT_W'(1);
            end else if (decVec[r] && !incVec[r]) begin
                cntNext[r] = cnt[r] - CNT_W'(1);
            end
            pendNext[r] = (cntNext[r] != '0);
        end
        errNext = ERR | (~FLUSH & WB_VALID & (cnt[WB_C] == '0));
    end

    // PC write sequencing: wait for the R15 write to retire, or abandon it on flush.
    always_comb begin
        stateNext = state;
        if (FLUSH) begin
            stateNext = RUN;
        end else if ((state == RUN) && ISSUE && ID_WR && (ID_C == 4'hF)) begin
            stateNext = PC_WAIT;
        end else if ((state == PC_WAIT) && (cntNext[15] == '0)) begin
            stateNext = RUN;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Counters, pending flags and the sticky error bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= '0;
            end
            PEND <= '0;
            ERR  <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= cntNext[r];
            end
            PEND <= pendNext;
            ERR  <= errNext;
        end
    end

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// tb_rf_hazard_scoreboard: scoreboard bench for rf_hazard_scoreboard.
// A reference model predicts outputs for every driven cycle; a checker pops
// the predictions and compares them against the DUT just before the next edge.
module tb_rf_hazard_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        CLK;
    logic        RST;
    logic        ID_VALID;
    logic [3:0]  ID_SA;
    logic [3:0]  ID_SB;
    logic [3:0]  ID_SD;
    logic [2:0]  ID_USE;
    logic        ID_WR;
    logic [3:0]  ID_C;
    logic        WB_VALID;
    logic [3:0]  WB_C;
    logic        FLUSH;
    logic        ISSUE;
    logic        STALL;
    logic        HZPCld;
    logic [15:0] PEND;
    logic        ERR;

    typedef struct packed {
        logic        issue;
        logic        stall;
        logic        hzpc;
        logic [15:0] pend;
        logic        err;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];

    int checkCount = 0;
    int errorCount = 0;

    int mCnt[16];
    bit mWait;
    bit mErr;

    rf_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ID_VALID (ID_VALID),
        .ID_SA    (ID_SA),
        .ID_SB    (ID_SB),
        .ID_SD    (ID_SD),
        .ID_USE   (ID_USE),
        .ID_WR    (ID_WR),
        .ID_C     (ID_C),
        .WB_VALID (WB_VALID),
        .WB_C     (WB_C),
        .FLUSH    (FLUSH),
        .ISSUE    (ISSUE),
        .STALL    (STALL),
        .HZPCld   (HZPCld),
        .PEND     (PEND),
        .ERR      (ERR)
    );

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, predict outputs, then advance the model.
    task automatic applyStimulus(input string tag, input bit rst, input bit v,
                                 input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sd,
                                 input logic [2:0] use_, input bit wr, input logic [3:0] c,
                                 input bit wbv, input logic [3:0] wbc, input bit fl);
        exp_t e;
        bit   haz;
        bit   incR;
        bit   decR;
        @(negedge CLK);
        RST = rst; ID_VALID = v; ID_SA = sa; ID_SB = sb; ID_SD = sd; ID_USE = use_;
        ID_WR = wr; ID_C = c; WB_VALID = wbv; WB_C = wbc; FLUSH = fl;
        #1;
        if (!rst) begin
            for (int r = 0; r < 16; r++) mCnt[r] = 0;
            mWait = 0;
            mErr  = 0;
        end
        haz = (use_[0] && mCnt[sa] != 0) || (use_[1] && mCnt[sb] != 0) ||
              (use_[2] && mCnt[sd] != 0) || (wr && mCnt[c] == MAXC);
        if (!rst) begin
            e.issue = 0; e.stall = 0; e.hzpc = 1;
        end else if (mWait) begin
            e.issue = 0; e.stall = 1; e.hzpc = 0;
        end else begin
            e.stall = v && haz;
            e.hzpc  = !(v && haz);
            e.issue = v && !haz && !fl;
        end
        for (int r = 0; r < 16; r++) e.pend[r] = (mCnt[r] != 0);
        e.err = mErr;
        expQ.push_back(e);
        tagQ.push_back(tag);
        if (rst) begin
            if (fl) begin
                for (int r = 0; r < 16; r++) mCnt[r] = 0;
                mWait = 0;
            end else begin
                if (wbv && mCnt[wbc] == 0) mErr = 1;
                if (!mWait && e.issue && wr && c == 4'hF) begin
                    mWait = 1;
                end
                for (int r = 0; r < 16; r++) begin
                    incR = e.issue && wr && (c == 4'(r));
                    decR = wbv && (wbc == 4'(r)) && mCnt[r] != 0;
                    if (incR && !decR) mCnt[r]++;
                    else if (decR && !incR) mCnt[r]--;
                end
                if (mWait && !(e.issue && wr && c == 4'hF) && mCnt[15] == 0) mWait = 0;
            end
        end
    endtask

    // Short helpers for the directed phases.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic wrOp(input string tag, input logic [3:0] c);
        applyStimulus(tag, 1, 1, 0, 0, 0, 3'b000, 1, c, 0, 0, 0);
    endtask

    task automatic wbOp(input string tag, input logic [3:0] c);
        applyStimulus(tag, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1, c, 0);
    endtask

    // Checker: pop each prediction just before the rising edge it refers to.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge CLK);
            #4;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                checkOutput({t, ".ISSUE"},  32'(ISSUE),  32'(e.issue));
                checkOutput({t, ".STALL"},  32'(STALL),  32'(e.stall));
                checkOutput({t, ".HZPCld"}, 32'(HZPCld), 32'(e.hzpc));
                checkOutput({t, ".PEND"},   32'(PEND),   32'(e.pend));
                checkOutput({t, ".ERR"},    32'(ERR),    32'(e.err));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a random phase.
    initial begin
        int sel;
        logic [3:0] idx [4];
        RST = 0; ID_VALID = 0; ID_SA = 0; ID_SB = 0; ID_SD = 0; ID_USE = 0;
        ID_WR = 0; ID_C = 0; WB_VALID = 0; WB_C = 0; FLUSH = 0;
        for (int r = 0; r < 16; r++) mCnt[r] = 0;
        mWait = 0; mErr = 0;

        // Reset holds outputs idle even with a valid instruction presented.
        applyStimulus("t1_rst", 0, 1, 0, 0, 0, 3'b000, 1, 4'd3, 0, 0, 0);
        applyStimulus("t1_rst", 0, 1, 0, 0, 0, 3'b000, 1, 4'd3, 0, 0, 0);
        applyStimulus("t1_rel", 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

        // RAW on R3; a same-cycle writeback does not bypass.
        wrOp("t2_wr3", 4'd3);
        applyStimulus("t2_raw", 1, 1, 4'd3, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        applyStimulus("t2_wb",  1, 1, 4'd3, 0, 0, 3'b001, 0, 0, 1, 4'd3, 0);
        applyStimulus("t2_go",  1, 1, 4'd3, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        applyStimulus("t2_sd",  1, 1, 0, 4'd1, 4'd0, 3'b100, 0, 0, 0, 0, 0);

        // Saturation of R5 at three outstanding writes.
        wrOp("t3_wr5a", 4'd5);
        wrOp("t3_wr5b", 4'd5);
        wrOp("t3_wr5c", 4'd5);
        wrOp("t3_sat", 4'd5);
        applyStimulus("t3_satwb", 1, 1, 0, 0, 0, 3'b000, 1, 4'd5, 1, 4'd5, 0);
        wrOp("t3_resume", 4'd5);
        wbOp("t3_drain", 4'd5);
        wbOp("t3_drain", 4'd5);
        wbOp("t3_drain", 4'd5);
        idle("t3_idle", 1);

        // Simultaneous issue and retire on R7, then R0 tracked like any register.
        wrOp("t4_wr7", 4'd7);
        applyStimulus("t4_both", 1, 1, 0, 0, 0, 3'b000, 1, 4'd7, 1, 4'd7, 0);
        idle("t4_hold", 1);
        wbOp("t4_wb7", 4'd7);
        wrOp("t4_wr0", 4'd0);
        applyStimulus("t4_rawb0", 1, 1, 0, 4'd0, 0, 3'b010, 0, 0, 0, 0, 0);
        wbOp("t4_wb0", 4'd0);

        // PC write: decode and PC held until R15 retires.
        wrOp("t5_wr15", 4'd15);
        applyStimulus("t5_wait", 1, 1, 4'd1, 0, 0, 3'b000, 1, 4'd2, 0, 0, 0);
        applyStimulus("t5_wait", 1, 1, 4'd1, 0, 0, 3'b000, 1, 4'd2, 0, 0, 0);
        applyStimulus("t5_wb15", 1, 1, 4'd1, 0, 0, 3'b000, 0, 0, 1, 4'd15, 0);
        applyStimulus("t5_run", 1, 1, 4'd1, 0, 0, 3'b000, 0, 0, 0, 0, 0);

        // Flush clears pending writes and PC_WAIT; a stray retire sets the sticky error.
        wrOp("t6_wr3", 4'd3);
        wrOp("t6_wr5", 4'd5);
        applyStimulus("t6_flush", 1, 1, 0, 0, 0, 3'b000, 1, 4'd4, 0, 0, 1);
        wrOp("t6_wr15", 4'd15);
        applyStimulus("t6_flushpc", 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        wbOp("t6_err", 4'd2);
        idle("t6_sticky", 2);
        applyStimulus("t6_flusherr", 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);

        // Reset mid-operation clears state without waiting for a clock edge.
        wrOp("t7_wr9", 4'd9);
        idle("t7_idle", 1);
        @(negedge CLK);
        #2;
        RST = 0;
        #1;
        checkOutput("t7_async.PEND", 32'(PEND), 32'h0);
        checkOutput("t7_async.ERR",  32'(ERR),  32'h0);
        applyStimulus("t7_rst", 0, 1, 0, 0, 0, 3'b000, 1, 4'd9, 0, 0, 0);
        applyStimulus("t7_rel", 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

        // Random traffic over a small register set, including R15.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                sel = $urandom_range(0, 4);
                idx[k] = (sel == 4) ? 4'hF : 4'(sel);
            end
            applyStimulus("rnd", 1, ($urandom_range(0, 3) != 0), idx[0], idx[1], idx[2],
                          3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), idx[3],
                          ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 4) == 4 ? 15 : $urandom_range(0, 3)),
                          ($urandom_range(0, 31) == 0));
        end

        idle("end", 1);
        @(negedge CLK);
        @(negedge CLK);
        if (expQ.size() != 0) begin
            checkOutput("queue_drain", 32'(expQ.size()), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
